// File: rtl/loa_sub_pipe_pkg.sv
// loa_pkg: shared defaults, half-width helper and mode encoding for the LOA subtractor
package loa_pkg;
  localparam int LOA_WIDTH_DEF = 32;
  localparam int LOA_LOW_BITS_DEF = 12;
  localparam logic LOA_MODE_APPROX = 1'b0;
  localparam logic LOA_MODE_EXACT = 1'b1;
  function automatic int loa_half(input int w);
    return w / 2;
  endfunction
endpackage

// File: rtl/loa_sub_pipe_rca.sv
// rca_sub_slice: ripple add of a and pre-inverted subtrahend, built from fa cells
// ports: a, b_inv, cin -> sum, cout (fa: a, b, ci -> s, co)
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module rca_sub_slice #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b_inv,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0] c;
  assign c[0] = cin;
  assign cout = c[N];
  for (genvar i = 0; i < N; i++) begin : g_fa
    fa u_fa (.a(a[i]), .b(b_inv[i]), .ci(c[i]), .s(sum[i]), .co(c[i+1]));
  end
endmodule

// File: rtl/loa_sub_pipe.sv
// loa_sub_pipe: 2-stage LOA approximate/exact subtractor with valid/ready on both sides
// in:  clk, rst_n (sync, active-low), in_valid, in_a, in_b, in_exact, out_ready
// out: in_ready, out_valid, out_diff, out_bout (1 = unsigned result wrapped)
module loa_sub_pipe
  import loa_pkg::*;
#(
  parameter int WIDTH = LOA_WIDTH_DEF,
  parameter int LOW_BITS = LOA_LOW_BITS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_exact,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_bout
);
  localparam int H = loa_half(WIDTH);
  localparam int U = WIDTH - H;
  localparam int M = H - LOW_BITS;
  logic v1, v2, en1, en2, exact, lo_cout, c_low, s1_c, r1_c, s2_cout;
  logic [WIDTH-1:0] b_inv;
  logic [LOW_BITS-1:0] lo_sum, lo_res;
  logic [H-1:0] s1_lo, r1_lo;
  logic [U-1:0] r1_a, r1_bn, s2_sum;
  assign en2 = ~v2 | out_ready;
  assign en1 = ~v1 | en2;
  assign in_ready = en1;
  assign out_valid = v2;
  assign b_inv = ~in_b;
  assign exact = in_exact == LOA_MODE_EXACT;
  rca_sub_slice #(.N(LOW_BITS)) u_lo (
    .a(in_a[LOW_BITS-1:0]), .b_inv(b_inv[LOW_BITS-1:0]), .cin(1'b1),
    .sum(lo_sum), .cout(lo_cout)
  );
  // approximate mode: OR lower part, carry generated from its top bit pair, no +1
  assign lo_res = exact ? lo_sum : in_a[LOW_BITS-1:0] | b_inv[LOW_BITS-1:0];
  assign c_low = exact ? lo_cout : in_a[LOW_BITS-1] & b_inv[LOW_BITS-1];
  if (M > 0) begin : g_mid
    logic [M-1:0] mid_sum;
    logic mid_cout;
    rca_sub_slice #(.N(M)) u_mid (
      .a(in_a[H-1:LOW_BITS]), .b_inv(b_inv[H-1:LOW_BITS]), .cin(c_low),
      .sum(mid_sum), .cout(mid_cout)
    );
    assign s1_lo = {mid_sum, lo_res};
    assign s1_c = mid_cout;
  end else begin : g_nomid
    assign s1_lo = lo_res;
    assign s1_c = c_low;
  end
  rca_sub_slice #(.N(U)) u_hi (
    .a(r1_a), .b_inv(r1_bn), .cin(r1_c), .sum(s2_sum), .cout(s2_cout)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      r1_lo <= '0;
      r1_c <= 1'b0;
      r1_a <= '0;
      r1_bn <= '0;
      out_diff <= '0;
      out_bout <= 1'b0;
    end else begin
      if (en1) begin
        v1 <= in_valid & in_ready;
        r1_lo <= s1_lo;
        r1_c <= s1_c;
        r1_a <= in_a[WIDTH-1:H];
        r1_bn <= b_inv[WIDTH-1:H];
      end
      if (en2) begin
        v2 <= v1;
        out_diff <= {s2_sum, r1_lo};
        out_bout <= ~s2_cout;
      end
    end
  end
endmodule
